pipe_stage_skid: RTL and testbench

- Generalised inter-stage pipeline register, the successor to the fixed decode-to-execute latch.
- Carries a parametrised payload plus a separate control bundle between any two pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so in_ready is fully registered, with no combinational path from out_ready.
- Supports hazard-unit flush and stall, plus a flush-protect mode for instructions already committed downstream.

---
 rtl/pipe_stage_skid.sv | 134 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: inter-stage pipeline register with a 2-entry skid buffer.
// The main register M drives the outputs and the skid register S catches the
// beat that arrives while downstream stalls. in_ready is registered, so there
// is no combinational path from out_ready. Hazard flush/stall are supported.
// Optional feature macro: PIPE_STAGE_PROTECT_EN adds flush_protect, which
// spares the head beat in M on a flush and kills only S.
module pipe_stage_skid #(
  parameter int DATA_W          = 32,
  parameter int CTRL_W          = 16,
  parameter int FLUSH_KEEP_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  input  logic              stall,
`ifdef PIPE_STAGE_PROTECT_EN
  input  logic              flush_protect,
`endif
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state, nState;
  logic [DATA_W-1:0] mData, sData, nMData, nSData;
  logic [CTRL_W-1:0] mCtrl, sCtrl, nMCtrl, nSCtrl;
  logic              inReadyQ;
  logic [1:0]        occQ, nOcc;
  logic              accept, emit, protect;

`ifdef PIPE_STAGE_PROTECT_EN
  assign protect = flush_protect;
`else
  assign protect = 1'b0;
`endif

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & inReadyQ & ~stall & ~flush;
  assign emit      = out_valid & out_ready & ~stall;

  // Next-state and next-register decode; flush overrides stall and accept.
  always_comb begin
    nState = state;
    nMData = mData;
    nMCtrl = mCtrl;
    nSData = sData;
    nSCtrl = sCtrl;
    if (flush) begin
      nSCtrl = '0;
      if (FLUSH_KEEP_DATA == 0) nSData = '0;
      // A protected flush keeps M unless it is leaving this cycle anyway;
      // a beat emitted alongside the flush has been delivered.
      if (protect && state != EMPTY && !emit) begin
        nState = ONE;
      end else begin
        nState = EMPTY;
        nMCtrl = '0;
        if (FLUSH_KEEP_DATA == 0) nMData = '0;
      end
    end else begin
      case (state)
        EMPTY: if (accept) begin
          nMData = in_data;
          nMCtrl = in_ctrl;
          nState = ONE;
        end
        ONE: begin
          if (accept && emit) begin
            nMData = in_data;
            nMCtrl = in_ctrl;
          end else if (accept) begin
            nSData = in_data;
            nSCtrl = in_ctrl;
            nState = TWO;
          end else if (emit) begin
            nState = EMPTY;
          end
        end
        TWO: if (emit) begin
          // S is never bypassed: it always moves into M before new input.
          nMData = sData;
          nMCtrl = sCtrl;
          nState = ONE;
        end
        default: nState = EMPTY;
      endcase
    end
  end

  // Occupancy follows the next state so it can be registered alongside it.
  always_comb begin
    nOcc = 2'd0;
    case (nState)
      ONE:     nOcc = 2'd1;
      TWO:     nOcc = 2'd2;
      default: nOcc = 2'd0;
    endcase
  end

  // State and storage registers; reset discards every held beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= EMPTY;
      mData    <= '0;
      mCtrl    <= '0;
      sData    <= '0;
      sCtrl    <= '0;
      inReadyQ <= 1'b0;
      occQ     <= 2'd0;
    end else begin
      state    <= nState;
      mData    <= nMData;
      mCtrl    <= nMCtrl;
      sData    <= nSData;
      sCtrl    <= nSCtrl;
      inReadyQ <= (nState != TWO);
      occQ     <= nOcc;
    end
  end

  assign in_ready  = inReadyQ;
  assign out_data  = mData;
  assign out_ctrl  = mCtrl & {CTRL_W{out_valid}};
  assign occupancy = occQ;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed testbench for pipe_stage_skid with hand-computed expectations.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [15:0] in_ctrl, out_ctrl;
  logic        flush, stall, flush_protect;
  logic [1:0]  occupancy;

  int nChecks = 0;
  int nErrors = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(16), .FLUSH_KEEP_DATA(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .stall(stall),
`ifdef PIPE_STAGE_PROTECT_EN
    .flush_protect(flush_protect),
`endif
    .occupancy(occupancy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are read 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [15:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_data = 32'h55; in_ctrl = 16'h55;
    out_ready = 1'b1; flush = 1'b0; stall = 1'b0; flush_protect = 1'b0;

    // Reset held with traffic present
    repeat (3) step();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_ctrl",  {16'b0, out_ctrl},  32'd0);
    chk("rst_out_data",  out_data,           32'd0);
    chk("rst_occ",       {30'b0, occupancy}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd0);
    rst = 1'b1; in_valid = 1'b0;
    step();
    chk("rel_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rel_out_valid", {31'b0, out_valid}, 32'd0);

    // Streaming, one beat per cycle
    for (int i = 0; i < 8; i++) begin
      push(32'h11 + i, 16'(i + 1));
      step();
      chk("strm_valid", {31'b0, out_valid}, 32'd1);
      chk("strm_data",  out_data,           32'h11 + i);
      chk("strm_ctrl",  {16'b0, out_ctrl},  32'(i + 1));
      chk("strm_occ",   {30'b0, occupancy}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("strm_drain_valid", {31'b0, out_valid}, 32'd0);
    chk("strm_drain_ctrl",  {16'b0, out_ctrl},  32'd0);
    chk("strm_drain_occ",   {30'b0, occupancy}, 32'd0);

    // Backpressure fills the skid register
    push(32'hA1, 16'hA1); step();
    out_ready = 1'b0;
    push(32'hA2, 16'hA2); step();
    chk("bp_occ2",     {30'b0, occupancy}, 32'd2);
    chk("bp_in_ready", {31'b0, in_ready},  32'd0);
    chk("bp_head",     out_data,           32'hA1);
    push(32'hA3, 16'hA3); step();
    chk("bp_hold_occ",  {30'b0, occupancy}, 32'd2);
    chk("bp_hold_head", out_data,           32'hA1);
    out_ready = 1'b1; step();
    chk("bp_a2",       out_data,           32'hA2);
    chk("bp_a2_occ",   {30'b0, occupancy}, 32'd1);
    chk("bp_a2_rdy",   {31'b0, in_ready},  32'd1);
    step();
    chk("bp_a3",       out_data,           32'hA3);
    chk("bp_a3_ctrl",  {16'b0, out_ctrl},  32'hA3);
    in_valid = 1'b0; step();
    chk("bp_drain_occ", {30'b0, occupancy}, 32'd0);

    // Stall freezes the stage
    push(32'hC1, 16'hC1); step();
    stall = 1'b1; push(32'hC2, 16'hC2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_data",  out_data,           32'hC1);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_occ",   {30'b0, occupancy}, 32'd1);
    end
    stall = 1'b0; step();
    chk("stall_rel_data", out_data, 32'hC2);
    in_valid = 1'b0; step();
    chk("stall_drain_occ", {30'b0, occupancy}, 32'd0);

    // Flush with two beats held and a beat presented
    out_ready = 1'b0;
    push(32'hD1, 16'hD1); step();
    push(32'hD2, 16'hD2); step();
    chk("fl_pre_occ", {30'b0, occupancy}, 32'd2);
    push(32'hFF, 16'hFFFF); flush = 1'b1; step();
    chk("fl_valid",    {31'b0, out_valid}, 32'd0);
    chk("fl_ctrl",     {16'b0, out_ctrl},  32'd0);
    chk("fl_occ",      {30'b0, occupancy}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready},  32'd1);
    chk("fl_data",     out_data,           32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk("fl_no_ff", {31'b0, out_valid}, 32'd0);

`ifdef PIPE_STAGE_PROTECT_EN
    // Protected flush keeps the head beat, kills the skid beat
    out_ready = 1'b0;
    push(32'hB1, 16'hB1); step();
    push(32'hB2, 16'hB2); step();
    in_valid = 1'b0; flush = 1'b1; flush_protect = 1'b1; step();
    chk("prot_valid", {31'b0, out_valid}, 32'd1);
    chk("prot_data",  out_data,           32'hB1);
    chk("prot_ctrl",  {16'b0, out_ctrl},  32'hB1);
    chk("prot_occ",   {30'b0, occupancy}, 32'd1);
    flush = 1'b0; flush_protect = 1'b0; out_ready = 1'b1; step();
    chk("prot_no_b2", {31'b0, out_valid}, 32'd0);
`endif

    // Reset mid-operation discards held beats
    out_ready = 1'b0;
    push(32'hE1, 16'hE1); step();
    push(32'hE2, 16'hE2); step();
    rst = 1'b0; step();
    chk("mid_rst_occ",   {30'b0, occupancy}, 32'd0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_rdy",   {31'b0, in_ready},  32'd0);
    rst = 1'b1; in_valid = 1'b0; step();
    chk("mid_rel_rdy",   {31'b0, in_ready},  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
